machine_timer: RTL and testbench
================================

MACHINE_TIMER -- requirements
Module: machine_timer

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h02000000, meaning base of the 32-byte register window (aligned to 32 bytes).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port memory_read  input  1  core bus read strobe.
REQ-005 SHALL have port memory_write  input  1  core bus write strobe.
REQ-006 SHALL have port option  input  3  access size: 3'b000 byte, 3'b001 halfword, 3'b010 word.
REQ-007 SHALL have port address  input  32  byte address from the core.
REQ-008 SHALL have port write_data  input  32  store data, right-aligned as produced by the core.
REQ-009 SHALL have port read_data  output  32  registered read data; 32'h0 when not addressed.
REQ-010 SHALL have port instruction_request_timer  output  1  machine timer interrupt request to the core.

Function
REQ-011 SHALL decode a hit when address[31:5] == BASE_ADDRESS[31:5]; offset = address[4:2].
REQ-012 SHALL implement these registers:
- 0x00 mtime_lo
- 0x04 mtime_hi
- 0x08 mtimecmp_lo
- 0x0C mtimecmp_hi
- 0x10 ctrl: bit0 enable; other bits read 0
- 0x14 prescale: bits[15:0]; bits[31:16] read 0
- 0x18 and 0x1C: read 0, writes ignored
REQ-013 SHALL keep a 16-bit prescale counter when enable=1: if counter == prescale, counter <= 0 and a tick occurs; else counter increments; prescale=0 gives a tick every cycle.
REQ-014 SHALL increment the 64-bit mtime by 1 on each tick, with carry from lo into hi, wrapping from 64'hFFFF_FFFF_FFFF_FFFF to 0.
REQ-015 SHALL freeze mtime and the prescale counter while enable=0.
REQ-016 SHALL apply writes (memory_write & hit) in the same clock edge, merging byte lanes into the addressed word:
- byte: lane address[1:0] takes write_data[7:0]
- halfword: lanes {address[1],0} and {address[1],1} take write_data[15:0]
- word: all lanes take write_data; address[1:0] ignored
- option values 3'b011..3'b111: treated as word
REQ-017 SHALL give a register write priority over a same-cycle tick for the written half of mtime. When only one half is written, the other half SHALL still see the tick, including carry from the pre-write lo.
REQ-018 SHALL reset the prescale counter to 0 on any write to prescale or ctrl.
REQ-019 SHALL register reads: on memory_read & hit, read_data <= addressed word (full 32 bits regardless of option), valid the cycle after the strobe. On any cycle without memory_read & hit, read_data <= 32'h0.
REQ-020 SHALL snapshot mtime_hi into a shadow register on every read of mtime_lo. Reads of mtime_hi SHALL return the shadow, giving a coherent 64-bit read when lo is read first.
REQ-021 SHALL ignore memory_read when memory_write is asserted in the same cycle; the write is performed and read_data <= 0.
REQ-022 SHALL register the interrupt: instruction_request_timer <= (mtime >= mtimecmp), unsigned 64-bit compare on the current register values. It asserts the cycle after the condition holds and deasserts the cycle after a mtimecmp/mtime write clears it.
REQ-023 SHALL compute the interrupt compare independently of enable; a disabled timer still holds the interrupt level.
REQ-024 SHALL require no handshake: accesses complete in one cycle, and back-to-back accesses every cycle are supported.

Reset
REQ-025 SHALL on reset set:
- mtime = 0
- shadow = 0
- mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
- enable = 0
- prescale = 0
- prescale counter = 0
- read_data = 0
- instruction_request_timer = 0
REQ-026 SHALL let reset override any same-cycle write or tick; an access during the reset cycle is lost.
REQ-027 SHALL after reset deassertion keep instruction_request_timer = 0 until software lowers mtimecmp or mtime reaches it.

Verification
REQ-028 Reset, then word write ctrl=1, prescale=0 -> mtime_lo reads 1 on the first tick cycle and increments by 1 per clock; read_data is 0 on idle cycles.
REQ-029 Write prescale=3, enable -> mtime increments once every 4 clocks; a mid-count write of prescale=3 restarts the 4-cycle spacing.
REQ-030 Disabled timer; write mtime_lo=32'hFFFFFFFF, mtime_hi=0; enable, prescale=0 -> next tick gives mtime_hi=1, mtime_lo=0. Read lo then hi -> 0 then 1 (shadow), even if a tick occurs between the reads.
REQ-031 Write mtimecmp={0,10}, mtime=0, enable, prescale=0 -> instruction_request_timer rises one cycle after mtime reaches 10. Writing mtimecmp_hi=1 drops it one cycle later.
REQ-032 Byte write 8'hAB at BASE+0x09 and halfword 16'h1234 at BASE+0x0A with mtimecmp_lo=0 -> mtimecmp_lo reads 32'h1234AB00. Access at BASE+0x20 -> no register changes, read_data=0.
REQ-033 Assert reset mid-count with interrupt high and a same-cycle write -> all state returns to REQ-025 values, the write is discarded, and the interrupt stays 0 afterwards.

Source files
------------

// File: rtl/machine_timer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp,
// registered read port with a coherent mtime_hi shadow, and a level interrupt.
module machine_timer #(
  parameter logic [31:0] BASE_ADDRESS = 32'h02000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [2:0]  option,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        instruction_request_timer
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] shadow;
  logic        enable;
  logic [15:0] prescale;
  logic [15:0] counter;

  logic        hit;
  logic [2:0]  offset;
  logic        wr_en;
  logic        rd_en;
  logic        tick;
  logic [63:0] mtime_inc;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic [31:0] bit_mask;
  logic [31:0] reg_word;
  logic [31:0] read_word;
  logic [31:0] merged;

  assign hit       = (address[31:5] == BASE_ADDRESS[31:5]);
  assign offset    = address[4:2];
  assign wr_en     = memory_write & hit;
  assign rd_en     = memory_read & hit & ~memory_write;
  assign tick      = enable && (counter == prescale);
  assign mtime_inc = mtime + {63'd0, tick};

  // Byte-lane enables and replicated store data for the access size; unknown sizes act as word.
  always_comb begin
    lane_mask = 4'b1111;
    lane_data = write_data;
    case (option)
      3'b000: begin
        lane_mask = 4'b0001 << address[1:0];
        lane_data = {4{write_data[7:0]}};
      end
      3'b001: begin
        lane_mask = address[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{write_data[15:0]}};
      end
      default: ;
    endcase
    bit_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
  end

  // Current value of the addressed register, used both for merging partial writes and for reads.
  always_comb begin
    reg_word  = 32'h0;
    read_word = 32'h0;
    case (offset)
      3'd0: reg_word = mtime[31:0];
      3'd1: reg_word = mtime[63:32];
      3'd2: reg_word = mtimecmp[31:0];
      3'd3: reg_word = mtimecmp[63:32];
      3'd4: reg_word = {31'd0, enable};
      3'd5: reg_word = {16'd0, prescale};
      default: reg_word = 32'h0;
    endcase
    read_word = (offset == 3'd1) ? shadow : reg_word;
    merged    = (reg_word & ~bit_mask) | (lane_data & bit_mask);
  end

  // Timer state: ticking mtime, prescaler, and register writes (a write beats the tick for its half).
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime    <= 64'd0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      enable   <= 1'b0;
      prescale <= 16'd0;
      counter  <= 16'd0;
    end else begin
      mtime <= mtime_inc;
      if (wr_en) begin
        case (offset)
          3'd0: mtime[31:0]     <= merged;
          3'd1: mtime[63:32]    <= merged;
          3'd2: mtimecmp[31:0]  <= merged;
          3'd3: mtimecmp[63:32] <= merged;
          3'd4: enable          <= merged[0];
          3'd5: prescale        <= merged[15:0];
          default: ;
        endcase
      end
      if (wr_en && (offset == 3'd4 || offset == 3'd5)) begin
        counter <= 16'd0;
      end else if (tick) begin
        counter <= 16'd0;
      end else if (enable) begin
        counter <= counter + 16'd1;
      end
    end
  end

  // Registered read port; reading mtime_lo captures mtime_hi so a lo-then-hi read pair is coherent.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data <= 32'h0;
      shadow    <= 32'h0;
    end else if (rd_en) begin
      read_data <= read_word;
      if (offset == 3'd0) begin
        shadow <= mtime[63:32];
      end
    end else begin
      read_data <= 32'h0;
    end
  end

  // Interrupt level follows the compare of the current registers, independent of enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction_request_timer <= 1'b0;
    end else begin
      instruction_request_timer <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: directed scenarios plus random bus
// traffic, compared every cycle against a behavioural model of the timer.
module tb_machine_timer;

  localparam logic [31:0] BASE = 32'h02000000;

  logic        clk;
  logic        reset;
  logic        memory_read;
  logic        memory_write;
  logic [2:0]  option;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        instruction_request_timer;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  logic [15:0] m_ps;
  logic [15:0] m_cnt;
  logic [31:0] m_shadow;
  logic [31:0] exp_rd;
  logic        exp_irq;

  machine_timer #(.BASE_ADDRESS(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .memory_read(memory_read),
    .memory_write(memory_write),
    .option(option),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .instruction_request_timer(instruction_request_timer)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] model_reg(input logic [2:0] idx);
    case (idx)
      3'd0: return m_mtime[31:0];
      3'd1: return m_mtime[63:32];
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {31'd0, m_en};
      3'd5: return {16'd0, m_ps};
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the reference model, computed from the pre-edge state
  task automatic model_step(input logic rst, input logic mr, input logic mw, input logic [2:0] opt,
                            input logic [31:0] addr, input logic [31:0] wd);
    logic [63:0] n_mtime, n_cmp;
    logic        n_en;
    logic [15:0] n_ps, n_cnt;
    logic [31:0] n_shadow, word;
    logic        ticking, hit;
    logic [2:0]  idx;
    int          nbytes, first;
    if (rst) begin
      m_mtime = 64'd0; m_cmp = '1; m_en = 1'b0; m_ps = 16'd0; m_cnt = 16'd0;
      m_shadow = 32'd0; exp_rd = 32'd0; exp_irq = 1'b0;
      return;
    end
    hit = (addr[31:5] == BASE[31:5]);
    idx = addr[4:2];
    exp_irq = (m_mtime >= m_cmp);
    ticking = m_en && (m_cnt == m_ps);
    n_mtime = ticking ? m_mtime + 64'd1 : m_mtime;
    n_cnt = m_en ? (ticking ? 16'd0 : m_cnt + 16'd1) : m_cnt;
    n_cmp = m_cmp; n_en = m_en; n_ps = m_ps; n_shadow = m_shadow;
    exp_rd = 32'd0;
    if (mr && hit && !mw) begin
      exp_rd = (idx == 3'd1) ? m_shadow : model_reg(idx);
      if (idx == 3'd0) n_shadow = m_mtime[63:32];
    end
    if (mw && hit) begin
      word = model_reg(idx);
      if (opt == 3'b000) begin nbytes = 1; first = int'(addr[1:0]); end
      else if (opt == 3'b001) begin nbytes = 2; first = addr[1] ? 2 : 0; end
      else begin nbytes = 4; first = 0; end
      for (int k = 0; k < nbytes; k++) word[8*(first+k) +: 8] = wd[8*k +: 8];
      case (idx)
        3'd0: n_mtime[31:0] = word;
        3'd1: n_mtime[63:32] = word;
        3'd2: n_cmp[31:0] = word;
        3'd3: n_cmp[63:32] = word;
        3'd4: begin n_en = word[0]; n_cnt = 16'd0; end
        3'd5: begin n_ps = word[15:0]; n_cnt = 16'd0; end
        default: ;
      endcase
    end
    m_mtime = n_mtime; m_cmp = n_cmp; m_en = n_en; m_ps = n_ps; m_cnt = n_cnt; m_shadow = n_shadow;
  endtask

  // Drive one bus cycle, advance DUT and model, and compare outputs just after the edge
  task automatic apply_stimulus(input logic rst, input logic mr, input logic mw, input logic [2:0] opt,
                                input logic [31:0] addr, input logic [31:0] wd);
    reset = rst; memory_read = mr; memory_write = mw; option = opt; address = addr; write_data = wd;
    @(posedge clk);
    model_step(rst, mr, mw, opt, addr, wd);
    #1;
    check_output("read_data", read_data, exp_rd);
    check_output("irq", {31'd0, instruction_request_timer}, {31'd0, exp_irq});
  endtask

  task automatic wr(input logic [7:0] off, input logic [2:0] opt, input logic [31:0] wd);
    apply_stimulus(1'b0, 1'b0, 1'b1, opt, BASE + {24'd0, off}, wd);
  endtask

  task automatic rd(input logic [7:0] off);
    apply_stimulus(1'b0, 1'b1, 1'b0, 3'b010, BASE + {24'd0, off}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
  endtask

  // Directed scenarios followed by random traffic
  initial begin
    logic [31:0] r, off, addr, wd;
    logic [2:0]  opt;
    logic        mr, mw, rst;
    reset = 1'b1; memory_read = 1'b0; memory_write = 1'b0; option = 3'b010;
    address = 32'd0; write_data = 32'd0;

    // Reset state
    do_reset();
    check_output("reset_read_data", read_data, 32'd0);
    check_output("reset_irq", {31'd0, instruction_request_timer}, 32'd0);
    rd(8'h0C);
    check_output("reset_cmp_hi", read_data, 32'hFFFF_FFFF);

    // Enable with prescale 0: mtime counts every clock
    do_reset();
    wr(8'h10, 3'b010, 32'd1);
    rd(8'h00); check_output("count_lo0", read_data, 32'd0);
    rd(8'h00); check_output("count_lo1", read_data, 32'd1);
    rd(8'h00); check_output("count_lo2", read_data, 32'd2);
    idle(1);   check_output("idle_read_zero", read_data, 32'd0);

    // Prescale 3: one tick every four clocks; rewriting prescale restarts the spacing
    do_reset();
    wr(8'h14, 3'b010, 32'd3);
    wr(8'h10, 3'b010, 32'd1);
    idle(4);
    rd(8'h00); check_output("ps3_first", read_data, 32'd1);
    idle(3);
    rd(8'h00); check_output("ps3_second", read_data, 32'd2);
    wr(8'h14, 3'b010, 32'd3);
    idle(3);
    rd(8'h00); check_output("ps3_restart_hold", read_data, 32'd2);
    rd(8'h00); check_output("ps3_restart_tick", read_data, 32'd3);

    // Carry from lo into hi, and coherent lo/hi read across a tick
    do_reset();
    wr(8'h00, 3'b010, 32'hFFFF_FFFF);
    wr(8'h04, 3'b010, 32'd0);
    wr(8'h14, 3'b010, 32'd0);
    wr(8'h10, 3'b010, 32'd1);
    idle(1);
    rd(8'h00); check_output("carry_lo", read_data, 32'd0);
    rd(8'h04); check_output("carry_hi_shadow", read_data, 32'd1);

    // Interrupt rises one cycle after mtime reaches mtimecmp, drops after mtimecmp_hi write
    do_reset();
    wr(8'h08, 3'b010, 32'd10);
    wr(8'h0C, 3'b010, 32'd0);
    wr(8'h00, 3'b010, 32'd0);
    wr(8'h04, 3'b010, 32'd0);
    wr(8'h10, 3'b010, 32'd1);
    idle(10);  check_output("irq_before", {31'd0, instruction_request_timer}, 32'd0);
    idle(1);   check_output("irq_rise", {31'd0, instruction_request_timer}, 32'd1);
    wr(8'h0C, 3'b010, 32'd1);
    check_output("irq_hold_on_write", {31'd0, instruction_request_timer}, 32'd1);
    idle(1);   check_output("irq_drop", {31'd0, instruction_request_timer}, 32'd0);

    // Byte and halfword lane merging; out-of-window access is ignored
    do_reset();
    wr(8'h08, 3'b010, 32'd0);
    wr(8'h09, 3'b000, 32'h0000_00AB);
    wr(8'h0A, 3'b001, 32'h0000_1234);
    rd(8'h08); check_output("lane_merge", read_data, 32'h1234_AB00);
    apply_stimulus(1'b0, 1'b0, 1'b1, 3'b010, BASE + 32'h20, 32'hDEAD_BEEF);
    apply_stimulus(1'b0, 1'b1, 1'b0, 3'b010, BASE + 32'h20, 32'd0);
    check_output("miss_read_zero", read_data, 32'd0);
    rd(8'h08); check_output("miss_no_change", read_data, 32'h1234_AB00);
    rd(8'h18); check_output("reserved_zero", read_data, 32'd0);

    // Reset with interrupt high and a same-cycle write
    do_reset();
    wr(8'h08, 3'b010, 32'd0);
    wr(8'h0C, 3'b010, 32'd0);
    wr(8'h10, 3'b010, 32'd1);
    idle(1);   check_output("irq_high_pre_reset", {31'd0, instruction_request_timer}, 32'd1);
    apply_stimulus(1'b1, 1'b0, 1'b1, 3'b010, BASE + 32'h14, 32'd5);
    check_output("reset_irq_low", {31'd0, instruction_request_timer}, 32'd0);
    idle(5);   check_output("irq_stays_low", {31'd0, instruction_request_timer}, 32'd0);
    rd(8'h14); check_output("reset_write_lost", read_data, 32'd0);
    rd(8'h00); check_output("reset_mtime_frozen", read_data, 32'd0);

    // Random bus traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r   = $urandom_range(0, 99);
      off = $urandom_range(0, 7);
      addr = (r < 8) ? (BASE + 32'h20 + {$urandom_range(0, 31)}) : (BASE + (off << 2) + {30'd0, 2'($urandom)});
      opt = 3'($urandom);
      mr  = 1'($urandom);
      mw  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 199) == 0);
      case (off)
        32'd1, 32'd3: wd = $urandom_range(0, 2);
        32'd4:        wd = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'd1;
        32'd5:        wd = $urandom_range(0, 3);
        default:      wd = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40);
      endcase
      apply_stimulus(rst, mr, mw, opt, addr, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
